clk_div_bank: RTL and testbench

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_bank.sv | 60 ++++++
 tb/tb_clk_div_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of independent clock dividers with shadowed per-channel config.
// Each channel outputs a toggle or pulse clock; a new config takes effect only at a period boundary.
module clk_div_bank #(
   parameter int NCH = 4,
   parameter int CW  = 8,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] ch_en,
   input  logic           sync_rst,
   input  logic           cfg_we,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [CW-1:0]  cfg_div,
   input  logic           cfg_mode,
   output logic [NCH-1:0] clk_out,
   output logic [NCH-1:0] cfg_pending
);
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam logic [CW-1:0] DEF = CW'((1 << i) - 1);
      logic [CW-1:0] cnt_q, cnt_d, act_n_q, act_n_d, sh_n_q, sh_n_d;
      logic act_m_q, act_m_d, sh_m_q, sh_m_d, pend_q, pend_d, out_q, out_d;
      logic wr, term, apply, clr;
      always_comb begin
         wr      = cfg_we && (cfg_ch == CHW'(i));
         term    = ch_en[i] && (cnt_q == act_n_q);
         clr     = sync_rst || !ch_en[i];
         // A write landing on the boundary replaces the shadow and waits for the next one.
         apply   = pend_q && !wr && (term || clr);
         sh_n_d  = wr ? cfg_div : sh_n_q;
         sh_m_d  = wr ? cfg_mode : sh_m_q;
         pend_d  = wr || (pend_q && !apply);
         act_n_d = apply ? sh_n_q : act_n_q;
         act_m_d = apply ? sh_m_q : act_m_q;
         cnt_d   = (clr || term) ? '0 : cnt_q + 1'b1;
         out_d   = (clr || (apply && (sh_m_q != act_m_q))) ? 1'b0 : act_m_q ? term : (out_q ^ term);
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q   <= '0;
            act_n_q <= DEF;
            sh_n_q  <= DEF;
            act_m_q <= 1'b0;
            sh_m_q  <= 1'b0;
            pend_q  <= 1'b0;
            out_q   <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            act_n_q <= act_n_d;
            sh_n_q  <= sh_n_d;
            act_m_q <= act_m_d;
            sh_m_q  <= sh_m_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
         end
      end
      assign clk_out[i]     = out_q;
      assign cfg_pending[i] = pend_q;
   end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: randomized and directed checks of clk_div_bank against a period-level model.
module tb_clk_div_bank;
   localparam int NCH = 4;
   localparam int CW  = 8;
   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] ch_en = '0;
   logic           sync_rst = 1'b0;
   logic           cfg_we = 1'b0;
   logic [1:0]     cfg_ch = '0;
   logic [CW-1:0]  cfg_div = '0;
   logic           cfg_mode = 1'b0;
   logic [NCH-1:0] clk_out, cfg_pending;
   int n_cmp = 0, n_err = 0;
   int mn[NCH], mm[NCH], sn[NCH], sm[NCH], pend[NCH], pos[NCH], done[NCH], lt[NCH];

   clk_div_bank #(.NCH(NCH), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .sync_rst(sync_rst), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
      .clk_out(clk_out), .cfg_pending(cfg_pending));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Model: pos = cycles into current period, done = periods completed since output last zeroed,
   // lt = previous cycle ended a period. Toggle output is the parity of done; pulse output is lt.
   function automatic logic [NCH-1:0] m_out();
      logic [NCH-1:0] r;
      for (int i = 0; i < NCH; i++) r[i] = (mm[i] != 0) ? (lt[i] != 0) : ((done[i] % 2) == 1);
      return r;
   endfunction

   function automatic logic [NCH-1:0] m_pend();
      logic [NCH-1:0] r;
      for (int i = 0; i < NCH; i++) r[i] = (pend[i] != 0);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         mn[i] = (1 << i) - 1; mm[i] = 0; sn[i] = mn[i]; sm[i] = 0;
         pend[i] = 0; pos[i] = 0; done[i] = 0; lt[i] = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < NCH; i++) begin
         bit en, wr, term, ap;
         en   = ch_en[i];
         wr   = cfg_we && (int'(cfg_ch) == i);
         term = en && (pos[i] == mn[i]);
         ap   = (pend[i] != 0) && !wr && (term || !en || sync_rst);
         if (sync_rst || !en) begin pos[i] = 0; done[i] = 0; lt[i] = 0; end
         else if (term) begin pos[i] = 0; done[i]++; lt[i] = 1; end
         else begin pos[i]++; lt[i] = 0; end
         if (ap) begin
            if (mm[i] != sm[i]) begin done[i] = 0; lt[i] = 0; end
            mn[i] = sn[i]; mm[i] = sm[i]; pend[i] = 0;
         end
         if (wr) begin sn[i] = int'(cfg_div); sm[i] = int'(cfg_mode); pend[i] = 1; end
      end
      #1;
   endtask

   task automatic write_cfg(input int ch, input int n, input bit m);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = CW'(n); cfg_mode = m;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      ch_en = '1;
      #1;
      n_cmp++; if (clk_out !== '0) begin n_err++; $display("FAIL reset_clk_out got=%b exp=%b", clk_out, 4'b0); end
      n_cmp++; if (cfg_pending !== '0) begin n_err++; $display("FAIL reset_pending got=%b exp=%b", cfg_pending, 4'b0); end
      @(posedge clk); @(posedge clk); #1;
      n_cmp++; if (clk_out !== '0) begin n_err++; $display("FAIL reset_held got=%b exp=%b", clk_out, 4'b0); end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_defaults();
      int first[NCH], second[NCH];
      logic [NCH-1:0] prev;
      for (int i = 0; i < NCH; i++) begin first[i] = -1; second[i] = -1; end
      prev = clk_out;
      for (int t = 1; t <= 40; t++) begin
         tick();
         n_cmp++; if (clk_out !== m_out()) begin n_err++; $display("FAIL defaults_out t=%0d got=%b exp=%b", t, clk_out, m_out()); end
         for (int i = 0; i < NCH; i++)
            if (!prev[i] && clk_out[i]) begin
               if (first[i] < 0) first[i] = t; else if (second[i] < 0) second[i] = t;
            end
         prev = clk_out;
      end
      for (int i = 0; i < NCH; i++) begin
         n_cmp++; if (first[i] != (1 << i)) begin n_err++; $display("FAIL defaults_first_rise ch%0d got=%0d exp=%0d", i, first[i], 1 << i); end
         n_cmp++; if (second[i] - first[i] != (2 << i)) begin n_err++; $display("FAIL defaults_period ch%0d got=%0d exp=%0d", i, second[i] - first[i], 2 << i); end
      end
   endtask

   task automatic test_pulse_switch();
      int k, highs;
      k = 0;
      while (pos[1] != 0 && k < 10) begin tick(); k++; end
      write_cfg(1, 4, 1'b1);
      n_cmp++; if (cfg_pending[1] !== 1'b1) begin n_err++; $display("FAIL pulse_pending_set got=%b exp=1", cfg_pending[1]); end
      k = 0;
      while (cfg_pending[1] && k < 20) begin
         tick(); k++;
         n_cmp++; if (cfg_pending !== m_pend()) begin n_err++; $display("FAIL pulse_pending got=%b exp=%b", cfg_pending, m_pend()); end
      end
      n_cmp++; if (cfg_pending[1] !== 1'b0) begin n_err++; $display("FAIL pulse_apply_timeout got=%b exp=0", cfg_pending[1]); end
      n_cmp++; if (clk_out[1] !== 1'b0) begin n_err++; $display("FAIL pulse_no_runt got=%b exp=0", clk_out[1]); end
      highs = 0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         n_cmp++; if (clk_out !== m_out()) begin n_err++; $display("FAIL pulse_out t=%0d got=%b exp=%b", t, clk_out, m_out()); end
         if (clk_out[1]) highs++;
      end
      n_cmp++; if (highs != 4) begin n_err++; $display("FAIL pulse_count got=%0d exp=4", highs); end
   endtask

   task automatic test_terminal_write();
      int k;
      logic prev;
      k = 0;
      while (pos[2] != mn[2] && k < 20) begin tick(); k++; end
      prev = clk_out[2];
      write_cfg(2, 5, 1'b0);
      n_cmp++; if (clk_out[2] === prev) begin n_err++; $display("FAIL term_toggle got=%b exp=%b", clk_out[2], ~prev); end
      n_cmp++; if (cfg_pending[2] !== 1'b1) begin n_err++; $display("FAIL term_pending got=%b exp=1", cfg_pending[2]); end
      for (int p = 0; p < 2; p++) begin
         prev = clk_out[2];
         k = 0;
         do begin
            tick(); k++;
            n_cmp++; if (clk_out !== m_out()) begin n_err++; $display("FAIL term_out got=%b exp=%b", clk_out, m_out()); end
         end while (clk_out[2] === prev && k < 30);
         n_cmp++; if (k != (p == 0 ? 4 : 6)) begin n_err++; $display("FAIL term_halfperiod%0d got=%0d exp=%0d", p, k, p == 0 ? 4 : 6); end
      end
   endtask

   task automatic test_disable();
      int k;
      ch_en[3] = 1'b0;
      for (int t = 0; t < 7; t++) begin
         tick();
         n_cmp++; if (clk_out[3] !== 1'b0) begin n_err++; $display("FAIL disable_low t=%0d got=%b exp=0", t, clk_out[3]); end
      end
      ch_en[3] = 1'b1;
      k = 0;
      do begin tick(); k++; end while (!clk_out[3] && k < 30);
      n_cmp++; if (k != 8) begin n_err++; $display("FAIL disable_first_rise got=%0d exp=8", k); end
      n_cmp++; if (clk_out !== m_out()) begin n_err++; $display("FAIL disable_out got=%b exp=%b", clk_out, m_out()); end
   endtask

   task automatic test_sync_rst();
      int k;
      write_cfg(0, 2, 1'b0);
      write_cfg(1, 2, 1'b0);
      k = 0;
      while (cfg_pending != '0 && k < 40) begin tick(); k++; end
      n_cmp++; if (cfg_pending !== '0) begin n_err++; $display("FAIL sync_apply got=%b exp=%b", cfg_pending, 4'b0); end
      write_cfg(0, 2, 1'b0);
      k = $urandom_range(3, 17);
      repeat (k) tick();
      sync_rst = 1'b1;
      tick();
      sync_rst = 1'b0;
      n_cmp++; if (clk_out !== '0) begin n_err++; $display("FAIL sync_clear got=%b exp=%b", clk_out, 4'b0); end
      n_cmp++; if (cfg_pending !== m_pend()) begin n_err++; $display("FAIL sync_pending got=%b exp=%b", cfg_pending, m_pend()); end
      for (int t = 1; t <= 24; t++) begin
         tick();
         n_cmp++; if (clk_out[0] !== clk_out[1]) begin n_err++; $display("FAIL sync_aligned t=%0d got=%b exp=%b", t, clk_out[0], clk_out[1]); end
         n_cmp++; if (clk_out !== m_out()) begin n_err++; $display("FAIL sync_out t=%0d got=%b exp=%b", t, clk_out, m_out()); end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 400; t++) begin
         cfg_we = ($urandom_range(0, 5) == 0);
         cfg_ch = 2'($urandom_range(0, NCH - 1));
         cfg_div = CW'($urandom_range(0, 6));
         cfg_mode = 1'($urandom_range(0, 1));
         sync_rst = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 11) == 0) ch_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
         tick();
         n_cmp++; if (clk_out !== m_out()) begin n_err++; $display("FAIL random_out t=%0d got=%b exp=%b", t, clk_out, m_out()); end
         n_cmp++; if (cfg_pending !== m_pend()) begin n_err++; $display("FAIL random_pending t=%0d got=%b exp=%b", t, cfg_pending, m_pend()); end
      end
      cfg_we = 1'b0; sync_rst = 1'b0; ch_en = '1;
      tick();
   endtask

   task automatic test_rst_mid();
      repeat ($urandom_range(2, 9)) tick();
      write_cfg(2, 9, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (clk_out !== '0) begin n_err++; $display("FAIL rstmid_out got=%b exp=%b", clk_out, 4'b0); end
      n_cmp++; if (cfg_pending !== '0) begin n_err++; $display("FAIL rstmid_pending got=%b exp=%b", cfg_pending, 4'b0); end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int t = 1; t <= 34; t++) begin
         tick();
         n_cmp++; if (clk_out !== m_out()) begin n_err++; $display("FAIL rstmid_defaults t=%0d got=%b exp=%b", t, clk_out, m_out()); end
         n_cmp++; if (cfg_pending !== '0) begin n_err++; $display("FAIL rstmid_nopend t=%0d got=%b exp=%b", t, cfg_pending, 4'b0); end
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_pulse_switch();
      test_terminal_write();
      test_disable();
      test_sync_rst();
      test_random();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
